// File: rtl/f15_depacketizer_if.sv
// Byte-stream depacketizer bus: 32-bit word input stream and unpacked byte output stream.
// master: the side that feeds words and drains bytes; slave: the depacketizer itself.
// Both streams use valid/ready; a transfer happens on valid & ready at a clock edge.
interface f15_depacketizer_if #(
  parameter int BIN_WIDTH = 6,
  parameter int ROW_WIDTH = 6
);
  logic [31:0]          in_data;
  logic                 in_last;
  logic                 in_eob;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           out_byte;
  logic [BIN_WIDTH-1:0] out_bin;
  logic [ROW_WIDTH-1:0] out_row;
  logic [1:0]           out_type;
  logic                 out_line_last;
  logic                 out_frame_last;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_len;
  logic                 err_seq;

  modport master (
    output in_data, in_last, in_eob, in_valid, out_ready,
    input  in_ready, out_byte, out_bin, out_row, out_type,
           out_line_last, out_frame_last, out_valid, err_len, err_seq
  );

  modport slave (
    input  in_data, in_last, in_eob, in_valid, out_ready,
    output in_ready, out_byte, out_bin, out_row, out_type,
           out_line_last, out_frame_last, out_valid, err_len, err_seq
  );
endinterface

// File: rtl/f15_depacketizer.sv
// Unpacks 32-bit words into bytes labelled with bin, histogram row and line type (histo/max/avg).
// Latency: first byte of a word appears 1 cycle after acceptance; 1 byte/cycle sustained.
// Backpressure: one-word buffer; in_ready only when the buffer is empty or its last byte leaves.
module f15_depacketizer #(
  parameter int BIN_WIDTH  = 6,
  parameter int ROW_WIDTH  = 6,
  parameter int HISTO_ROWS = 64
) (
  input logic            clk,
  input logic            rst,
  f15_depacketizer_if.slave bus
);

  localparam int WPL = 1 << (BIN_WIDTH - 2);              // words per full line
  localparam int WCW = (BIN_WIDTH > 2) ? BIN_WIDTH - 2 : 1;
  localparam logic [WCW-1:0]       WLAST    = WCW'(WPL - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(HISTO_ROWS - 1);

  typedef enum logic [1:0] {
    ST_HISTO = 2'd0,
    ST_MAX   = 2'd1,
    ST_AVG   = 2'd2
  } state_t;

  // Line tracking is done at word acceptance so every word is labelled as it enters the buffer.
  state_t                state_q, state_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;

  logic [1:0]            byte_idx;
  logic                  line_end_q;
  logic                  frame_end_q;
  logic [23:0]           data_q;

  logic                  accept;
  logic                  advance;
  logic                  full_word;
  logic                  eob_eff;
  logic                  line_end;
  logic                  frame_end;
  logic                  err_len_d;
  logic                  err_seq_d;

  assign bus.in_ready = !bus.out_valid | (byte_idx == 2'd3 & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign advance      = bus.out_valid & bus.out_ready;
  assign full_word    = (wcnt_q == WLAST);
  assign eob_eff      = bus.in_last & bus.in_eob;   // eob only means something on a last word

  // Line-type, row and word-position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HISTO;
      row_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Decide line boundary, next line type/row and error pulses for the word being accepted.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wcnt_d    = wcnt_q;
    line_end  = 1'b0;
    frame_end = 1'b0;
    err_len_d = 1'b0;
    err_seq_d = 1'b0;
    if (accept) begin
      // A line ends on in_last or when the full word count is reached; either without the other is a length error.
      line_end  = bus.in_last | full_word;
      err_len_d = bus.in_last ^ full_word;
      wcnt_d    = line_end ? '0 : wcnt_q + WCW'(1);
      if (line_end) begin
        unique case (state_q)
          ST_HISTO: begin
            if (eob_eff) begin
              err_seq_d = 1'b1;
              row_d     = '0;
            end else if (row_q == ROW_LAST) begin
              state_d = ST_MAX;
              row_d   = '0;
            end else begin
              row_d = row_q + ROW_WIDTH'(1);
            end
          end
          ST_MAX: begin
            if (eob_eff) begin
              err_seq_d = 1'b1;
              state_d   = ST_HISTO;
            end else begin
              state_d = ST_AVG;
            end
          end
          ST_AVG: begin
            // The avg line closes the frame whether or not eob arrived with it.
            frame_end = 1'b1;
            err_seq_d = !eob_eff;
            state_d   = ST_HISTO;
            row_d     = '0;
          end
          default: begin
            state_d = ST_HISTO;
            row_d   = '0;
          end
        endcase
      end
    end
  end

  // Output control: load labels on acceptance, step bin/index per emitted byte, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_line_last  <= 1'b0;
      bus.out_frame_last <= 1'b0;
      bus.out_bin        <= '0;
      bus.out_row        <= '0;
      bus.out_type       <= 2'd0;
      bus.err_len        <= 1'b0;
      bus.err_seq        <= 1'b0;
      byte_idx           <= 2'd0;
      line_end_q         <= 1'b0;
      frame_end_q        <= 1'b0;
    end else begin
      bus.err_len <= err_len_d;
      bus.err_seq <= err_seq_d;
      if (accept) begin
        bus.out_valid      <= 1'b1;
        bus.out_line_last  <= 1'b0;
        bus.out_frame_last <= 1'b0;
        bus.out_bin        <= BIN_WIDTH'({wcnt_q, 2'b00});
        bus.out_row        <= row_q;
        bus.out_type       <= state_q;
        byte_idx           <= 2'd0;
        line_end_q         <= line_end;
        frame_end_q        <= frame_end;
      end else if (advance) begin
        if (byte_idx == 2'd3) begin
          bus.out_valid      <= 1'b0;
          bus.out_line_last  <= 1'b0;
          bus.out_frame_last <= 1'b0;
        end else begin
          byte_idx           <= byte_idx + 2'd1;
          bus.out_bin        <= bus.out_bin + BIN_WIDTH'(1);
          bus.out_line_last  <= (byte_idx == 2'd2) & line_end_q;
          bus.out_frame_last <= (byte_idx == 2'd2) & frame_end_q;
        end
      end
    end
  end

  // Byte shifter; contents are don't-care while out_valid is low, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bus.out_byte <= bus.in_data[31:24];
      data_q       <= bus.in_data[23:0];
    end else if (advance && byte_idx != 2'd3) begin
      bus.out_byte <= data_q[23:16];
      data_q       <= {data_q[15:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_f15_depacketizer.sv
// Bench for f15_depacketizer: directed frames plus a randomized run against a line-ordinal model.
// Inputs change #1 after posedge; everything is sampled on the negedge.
// Expected labels come from the line's position in the frame, not from any RTL state.
module tb_f15_depacketizer;
  localparam int BW  = 4;
  localparam int RW  = 4;
  localparam int HR  = 2;
  localparam int WPL = 1 << (BW - 2);

  typedef struct packed {
    logic [7:0]    b;
    logic [BW-1:0] bin;
    logic [RW-1:0] row;
    logic [1:0]    typ;
    logic          ll;
    logic          fl;
  } rec_t;

  logic clk;
  logic rst;
  f15_depacketizer_if #(.BIN_WIDTH(BW), .ROW_WIDTH(RW)) bus ();
  f15_depacketizer #(.BIN_WIDTH(BW), .ROW_WIDTH(RW), .HISTO_ROWS(HR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests, fails;
  rec_t expq[$];
  rec_t obs_q[$];
  int   m_line, m_pos;
  logic exp_el, exp_es;
  logic acc;
  int   rdy_mode;
  logic hold;
  logic [31:0] snap;
  int   n_bytes, n_ll, n_fl, n_el, n_es, first_ll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a line is identified by its ordinal in the frame (0..HR-1 histo, HR max, HR+1 avg).
  task automatic model_word(input logic [31:0] d, input logic l, input logic e);
    rec_t r;
    logic ends;
    ends   = l || (m_pos == WPL - 1);
    exp_el = l ? (m_pos != WPL - 1) : (m_pos == WPL - 1);
    exp_es = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r.b   = 8'((d >> (24 - 8 * k)) & 32'hFF);
      r.bin = BW'(m_pos * 4 + k);
      r.row = (m_line < HR) ? RW'(m_line) : '0;
      r.typ = (m_line < HR) ? 2'd0 : 2'(m_line - HR + 1);
      r.ll  = ends && (k == 3);
      r.fl  = r.ll && (m_line == HR + 1);
      expq.push_back(r);
    end
    if (ends) begin
      if (m_line == HR + 1) begin
        exp_es = !(l && e);
        m_line = 0;
      end else if (l && e) begin
        exp_es = 1'b1;
        m_line = 0;
      end else begin
        m_line++;
      end
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic clear_stats();
    n_bytes = 0; n_ll = 0; n_fl = 0; n_el = 0; n_es = 0; first_ll = -1;
    obs_q.delete();
  endtask

  // One clock: check everything at negedge, feed the model on acceptance, then move to posedge+1.
  task automatic tick();
    rec_t o, e;
    logic [31:0] cur;
    @(negedge clk);
    chk("err_len", bus.err_len, exp_el);
    chk("err_seq", bus.err_seq, exp_es);
    if (bus.err_len) n_el++;
    if (bus.err_seq) n_es++;
    exp_el = 1'b0;
    exp_es = 1'b0;
    cur = {11'd0, bus.out_valid, bus.out_byte, bus.out_bin, bus.out_row, bus.out_type,
           bus.out_line_last, bus.out_frame_last};
    if (hold) chk("hold_stable", cur, snap);
    hold = bus.out_valid && !bus.out_ready;
    snap = cur;
    chk("in_ready", bus.in_ready,
        (expq.size() == 0) || (expq.size() == 1 && bus.out_ready));
    if (bus.out_valid && bus.out_ready) begin
      o = '{b: bus.out_byte, bin: bus.out_bin, row: bus.out_row, typ: bus.out_type,
            ll: bus.out_line_last, fl: bus.out_frame_last};
      obs_q.push_back(o);
      if (o.ll && first_ll < 0) first_ll = n_bytes;
      if (o.ll) n_ll++;
      if (o.fl) n_fl++;
      n_bytes++;
      if (expq.size() == 0) begin
        chk("unexpected_byte", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("byte", {24'd0, o.b}, {24'd0, e.b});
        chk("labels", {20'd0, o.bin, o.row, o.typ, o.ll, o.fl},
                      {20'd0, e.bin, e.row, e.typ, e.ll, e.fl});
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) model_word(bus.in_data, bus.in_last, bus.in_eob);
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = !bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic e);
    int budget;
    budget = 200;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_eob   = e;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      tick();
      budget--;
    end
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_line(input int n, input logic eob);
    for (int i = 0; i < n; i++)
      send_word($urandom, i == n - 1, (i == n - 1) && eob);
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    bus.in_valid = 1'b0;
    while ((expq.size() != 0 || bus.out_valid) && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_line_last", {31'd0, bus.out_line_last}, 32'd0);
    chk("rst_frame_last", {31'd0, bus.out_frame_last}, 32'd0);
    chk("rst_errs", {30'd0, bus.err_len, bus.err_seq}, 32'd0);
    chk("rst_bin_row_type", {22'd0, bus.out_bin, bus.out_row, bus.out_type}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    m_line = 0; m_pos = 0;
    exp_el = 1'b0; exp_es = 1'b0;
    hold = 1'b0;
    clear_stats();
  endtask

  initial begin
    int drv_pos;
    logic l, e;
    tests = 0; fails = 0; rdy_mode = 0; hold = 1'b0; snap = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_eob = 1'b0;
    bus.out_ready = 1'b1;
    do_reset();

    // Nominal frame: two histo lines, max, avg with eob.
    for (int ln = 0; ln < 4; ln++) send_line(4, ln == 3);
    drain();
    chk("nom_bytes", n_bytes, 64);
    chk("nom_line_last", n_ll, 4);
    chk("nom_frame_last", n_fl, 1);
    chk("nom_errors", n_el + n_es, 0);

    // Byte order within a word.
    do_reset();
    send_word(32'hA1B2C3D4, 1'b0, 1'b0);
    send_word($urandom, 1'b0, 1'b0);
    send_word($urandom, 1'b0, 1'b0);
    send_word($urandom, 1'b1, 1'b0);
    drain();
    chk("order_b0", {24'd0, obs_q[0].b}, 32'hA1);
    chk("order_b1", {24'd0, obs_q[1].b}, 32'hB2);
    chk("order_b2", {24'd0, obs_q[2].b}, 32'hC3);
    chk("order_b3", {24'd0, obs_q[3].b}, 32'hD4);
    chk("order_bin3", {28'd0, obs_q[3].bin}, 32'd3);

    // Backpressure: out_ready toggles every cycle through a full frame.
    do_reset();
    rdy_mode = 1;
    for (int ln = 0; ln < 4; ln++) send_line(4, ln == 3);
    drain();
    chk("bp_bytes", n_bytes, 64);
    chk("bp_frame_last", n_fl, 1);
    rdy_mode = 0;

    // Short histo line of 3 words, then a full line that must be row 1.
    do_reset();
    send_line(3, 1'b0);
    send_line(4, 1'b0);
    drain();
    chk("short_first_ll", first_ll, 11);
    chk("short_err_len", n_el, 1);
    chk("short_next_row", {28'd0, obs_q[12].row}, 32'd1);

    // Early eob on the line that should be max.
    do_reset();
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    send_line(4, 1'b1);
    send_line(4, 1'b0);
    drain();
    chk("eob_err_seq", n_es, 1);
    chk("eob_next_type_row", {26'd0, obs_q[48].typ, obs_q[48].row}, 32'd0);

    // Randomized traffic with random stalls, gaps, short/long lines and stray eobs.
    do_reset();
    rdy_mode = 2;
    drv_pos = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      l = (drv_pos == WPL - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      e = l && ($urandom_range(0, 2) == 0);
      send_word($urandom, l, $urandom_range(0, 3) == 0 ? 1'b1 : e);
      drv_pos = (l || drv_pos == WPL - 1) ? 0 : drv_pos + 1;
    end
    drain();
    rdy_mode = 0;

    // Reset after six bytes abandons the line; the next line restarts at bin 0, row 0, type 0.
    do_reset();
    send_word($urandom, 1'b0, 1'b0);
    send_word($urandom, 1'b0, 1'b0);
    for (int k = 0; k < 20 && n_bytes < 6; k++) tick();
    chk("rst_mid_bytes", n_bytes, 6);
    do_reset();
    send_line(4, 1'b0);
    drain();
    chk("after_rst_first", {22'd0, obs_q[0].bin, obs_q[0].row, obs_q[0].typ}, 32'd0);
    chk("after_rst_bytes", n_bytes, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
